// File: rtl/btn_conditioner.sv
// btn_conditioner: five independent button channels, each with a two-flop
// synchroniser and a debounce FSM. Each channel produces a debounced level
// (dpb) and a one-cycle enable (scen) per accepted press.
module btn_conditioner #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int CNT_W     = 20
) (
    input  logic Clk,
    input  logic reset_n,
    input  logic BtnL_raw,
    input  logic BtnR_raw,
    input  logic BtnU_raw,
    input  logic BtnD_raw,
    input  logic BtnC_raw,
    output logic BtnL_dpb,
    output logic BtnR_dpb,
    output logic BtnU_dpb,
    output logic BtnD_dpb,
    output logic BtnC_dpb,
    output logic BtnL_scen,
    output logic BtnR_scen,
    output logic BtnU_scen,
    output logic BtnD_scen,
    output logic BtnC_scen
);

    // IDLE: released, WQ: qualifying a press, SCEN: one-cycle pulse,
    // HOLD: pressed, WR: qualifying a release.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WQ   = 3'd1,
        SCEN = 3'd2,
        HOLD = 3'd3,
        WR   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Channel order: bit 0 = L, 1 = R, 2 = U, 3 = D, 4 = C.
    logic [4:0] raw_w;
    logic [4:0] dpb_w;
    logic [4:0] scen_w;

    assign raw_w = {BtnC_raw, BtnD_raw, BtnU_raw, BtnR_raw, BtnL_raw};

    for (genvar ch = 0; ch < 5; ch++) begin : g_chan
        logic             s1_q;
        logic             s2_q;
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             scen_q;
        logic             dpb_q;

        // Next-state and counter logic; any stray encoding falls back to IDLE.
        always_comb begin
            // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                IDLE: begin
                    if (s2_q) begin
                        state_d = WQ;
                        cnt_d   = '0;
                    end
                end
                WQ: begin
                    if (!s2_q)                 state_d = IDLE;
                    else if (cnt_q == CNT_LAST) state_d = SCEN;
                    else                       cnt_d   = cnt_q + CNT_ONE;
                end
                SCEN: state_d = HOLD;
                HOLD: begin
                    if (!s2_q) begin
                        state_d = WR;
                        cnt_d   = '0;
                    end
                end
                WR: begin
                    if (s2_q)                  state_d = HOLD;
                    else if (cnt_q == CNT_LAST) state_d = IDLE;
                    else                       cnt_d   = cnt_q + CNT_ONE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Synchroniser, FSM state, counter and Moore outputs registered together.
        always_ff @(posedge Clk) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            if (!reset_n) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                state_q <= IDLE;
                cnt_q   <= '0;
                scen_q  <= 1'b0;
                dpb_q   <= 1'b0;
            end else begin
                s1_q    <= raw_w[ch];
                s2_q    <= s1_q;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                scen_q  <= (state_d == SCEN);
                dpb_q   <= (state_d inside {SCEN, HOLD, WR});
            end
        end

        assign scen_w[ch] = scen_q;
        assign dpb_w[ch]  = dpb_q;
    end

    assign BtnL_dpb  = dpb_w[0];
    assign BtnR_dpb  = dpb_w[1];
    assign BtnU_dpb  = dpb_w[2];
    assign BtnD_dpb  = dpb_w[3];
    assign BtnC_dpb  = dpb_w[4];
    assign BtnL_scen = scen_w[0];
    assign BtnR_scen = scen_w[1];
    assign BtnU_scen = scen_w[2];
    assign BtnD_scen = scen_w[3];
    assign BtnC_scen = scen_w[4];

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DB_CYCLES=4, CNT_W=3.
// Each cycle's expected outputs are written from the timing rules, queued
// when the stimulus is driven, and popped/compared after the clock edge.
module tb_btn_conditioner;

    localparam int DB_CYCLES = 4;
    localparam int CNT_W     = 3;

    // Channel bit positions in the 5-bit vectors: L, R, U, D, C.
    localparam logic [4:0] M_L    = 5'b00001;
    localparam logic [4:0] M_R    = 5'b00010;
    localparam logic [4:0] M_U    = 5'b00100;
    localparam logic [4:0] M_D    = 5'b01000;
    localparam logic [4:0] M_C    = 5'b10000;
    localparam logic [4:0] M_ALL  = 5'b11111;
    localparam logic [4:0] M_NONE = 5'b00000;

    logic Clk;
    logic reset_n;
    logic [4:0] raw;
    logic [4:0] dpb;
    logic [4:0] scen;

    typedef struct {
        string      tag;
        logic [4:0] scen;
        logic [4:0] dpb;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    btn_conditioner #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) dut (
        .Clk       (Clk),
        .reset_n   (reset_n),
        .BtnL_raw  (raw[0]),
        .BtnR_raw  (raw[1]),
        .BtnU_raw  (raw[2]),
        .BtnD_raw  (raw[3]),
        .BtnC_raw  (raw[4]),
        .BtnL_dpb  (dpb[0]),
        .BtnR_dpb  (dpb[1]),
        .BtnU_dpb  (dpb[2]),
        .BtnD_dpb  (dpb[3]),
        .BtnC_dpb  (dpb[4]),
        .BtnL_scen (scen[0]),
        .BtnR_scen (scen[1]),
        .BtnU_scen (scen[2]),
        .BtnD_scen (scen[3]),
        .BtnC_scen (scen[4])
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // One clock cycle: drive inputs on the falling edge, queue the expected
    // outputs for after the next rising edge, then pop and compare.
    task automatic cyc(input string tag, input int n, input logic [4:0] raw_v,
                       input logic [4:0] exp_scen, input logic [4:0] exp_dpb,
                       input logic rst_v);
        exp_t e;
        @(negedge Clk);
        raw     = raw_v;
        reset_n = rst_v;
        e.tag  = $sformatf("%s@%0d", tag, n);
        e.scen = exp_scen;
        e.dpb  = exp_dpb;
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        assert (scen === e.scen) else begin
            errors++;
            $error("FAIL %s scen observed=%b expected=%b", e.tag, scen, e.scen);
        end
        checks++;
        assert (dpb === e.dpb) else begin
            errors++;
            $error("FAIL %s dpb observed=%b expected=%b", e.tag, dpb, e.dpb);
        end
    endtask

    initial begin
        raw     = M_NONE;
        reset_n = 1'b0;

        // Reset state: everything 0 after the reset edges.
        for (int n = 1; n <= 3; n++)
            cyc("reset", n, M_NONE, M_NONE, M_NONE, 1'b0);
        for (int n = 1; n <= 3; n++)
            cyc("post_reset", n, M_NONE, M_NONE, M_NONE, 1'b1);

        // Clean press on U: held edges 1..20, pulse after edge 7,
        // level 7..26 (falls 7 edges after raw drops before edge 21).
        for (int n = 1; n <= 30; n++)
            cyc("clean_press", n,
                (n <= 20) ? M_U : M_NONE,
                (n == 7) ? M_U : M_NONE,
                (n >= 7 && n <= 26) ? M_U : M_NONE, 1'b1);

        // Press bounce on R: high 1..3, low 4, high 5..14. Final rise before
        // edge 5 -> pulse after edge 11, level 11..20.
        for (int n = 1; n <= 25; n++)
            cyc("press_bounce", n,
                ((n <= 3) || (n >= 5 && n <= 14)) ? M_R : M_NONE,
                (n == 11) ? M_R : M_NONE,
                (n >= 11 && n <= 20) ? M_R : M_NONE, 1'b1);

        // Release bounce on D: high 1..12, low 13..14, high 15..20, low after.
        // Level stays up through the glitch and falls after edge 27.
        for (int n = 1; n <= 32; n++)
            cyc("release_bounce", n,
                ((n <= 12) || (n >= 15 && n <= 20)) ? M_D : M_NONE,
                (n == 7) ? M_D : M_NONE,
                (n >= 7 && n <= 26) ? M_D : M_NONE, 1'b1);

        // Simultaneous L and C: both pulse after edge 7, level 7..18.
        for (int n = 1; n <= 24; n++)
            cyc("simultaneous", n,
                (n <= 12) ? (M_L | M_C) : M_NONE,
                (n == 7) ? (M_L | M_C) : M_NONE,
                (n >= 7 && n <= 18) ? (M_L | M_C) : M_NONE, 1'b1);

        // Reset while U is in HOLD (edge 11), raw still high. Outputs clear,
        // then re-qualification gives one pulse after edge 18; raw drops
        // before edge 23 so the level runs 18..28.
        for (int n = 1; n <= 32; n++)
            cyc("reset_mid_press", n,
                (n <= 22) ? M_U : M_NONE,
                (n == 7 || n == 18) ? M_U : M_NONE,
                ((n >= 7 && n <= 10) || (n >= 18 && n <= 28)) ? M_U : M_NONE,
                (n == 11) ? 1'b0 : 1'b1);

        // Short glitches on every input: 1-cycle then 3-cycle pulses.
        for (int n = 1; n <= 16; n++)
            cyc("short_glitch", n,
                ((n == 1) || (n >= 7 && n <= 9)) ? M_ALL : M_NONE,
                M_NONE, M_NONE, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end input stage for the tic-tac-toe game controller. It takes the five raw board push-buttons (L, R, U, D, C), synchronises each one to `Clk` and debounces it. For every button it produces a debounced level and a single-clock pulse, one pulse per physical press. The pulses drive the game FSM's `BtnL`/`BtnR`/`BtnU`/`BtnD`/`BtnC` inputs directly, so each press advances cursor/placement logic exactly once.

## Interface
- `DB_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a press or a release (10 ms at 100 MHz). Legal range is 2 to 2^`CNT_W`.
- `CNT_W`, default 20: width of each per-button stability counter.
- `Clk`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  reset, synchronous, active-low. Sampled on the `Clk` rising edge.
- `BtnL_raw`, `BtnR_raw`, `BtnU_raw`, `BtnD_raw`, `BtnC_raw`  in  1 each  raw asynchronous button inputs, active-high.
- `BtnL_dpb` … `BtnC_dpb`  out  1 each  debounced button level.
- `BtnL_scen` … `BtnC_scen`  out  1 each  single-clock enable: high for exactly one cycle per accepted press.

## Operation
- Five identical, fully independent channels. Simultaneous presses are processed in parallel, with no priority and no interaction between channels.
- Synchroniser per channel: `s1 <= raw`, then `s2 <= s1`. The FSM sees only `s2`.
- FSM per channel has states IDLE, WQ (wait quiet on press), SCEN, HOLD, WR (wait quiet on release), plus counter `cnt[CNT_W-1:0]`.
  - IDLE: if `s2`=1, go to WQ with `cnt`<=0. Otherwise stay.
  - WQ: if `s2`=0, go to IDLE (bounce rejected). Else if `cnt`==`DB_CYCLES`-1, go to SCEN. Else `cnt`<=`cnt`+1.
  - SCEN: unconditionally go to HOLD next cycle, whatever `s2` is.
  - HOLD: if `s2`=0, go to WR with `cnt`<=0. Otherwise stay. A held button never re-pulses (no auto-repeat).
  - WR: if `s2`=1, go to HOLD (release bounce rejected). Else if `cnt`==`DB_CYCLES`-1, go to IDLE. Else `cnt`<=`cnt`+1.
- Outputs are Moore, decoded from state:
  - `scen`=1 only in SCEN.
  - `dpb`=1 in SCEN, HOLD and WR; `dpb`=0 in IDLE and WQ.
- Counter wrap is impossible: it is cleared on every WQ/WR entry and stops at `DB_CYCLES`-1.
- Unreachable state encodings return to IDLE on the next clock.

## Timing
- Reset: while `reset_n`=0 at a rising edge, every synchroniser flop, counter and FSM is cleared (FSM to IDLE). All outputs are 0 from the cycle after that edge. There is no asynchronous effect.
- Reset asserted mid-operation (any state, including SCEN) aborts the channel immediately. A button still held after reset release must be re-qualified from IDLE, and produces one new pulse.
- Press latency: raw goes high before edge 1 and stays high. `s2` is high after edge 2 and the FSM enters WQ after edge 3. SCEN is entered after edge `DB_CYCLES`+3. `scen` and `dpb` rise together there, and `scen` falls after edge `DB_CYCLES`+4.
- Release latency: symmetric. `dpb` falls `DB_CYCLES`+3 edges after raw falls.
- Any glitch on `s2` during WQ or WR restarts qualification from scratch.
- A glitch shorter than `DB_CYCLES` cycles never produces `scen`.
- Minimum spacing between two `scen` pulses on one channel is 2·`DB_CYCLES`+3 cycles.

## Test plan
All scenarios use `DB_CYCLES`=4 and `CNT_W`=3.
- Clean press: raise `BtnU_raw` before edge 1 and hold 20 cycles -> `BtnU_scen`=1 only in the cycle after edge 7; `BtnU_dpb`=1 from edge 7 onward; no second pulse.
- Press bounce: `BtnR_raw` high 3 cycles, low 1, then high 10 -> no pulse during the first burst; exactly one pulse, 7 cycles after the final rise.
- Release bounce: while held, drop `BtnD_raw` for 2 cycles, restore it, then release cleanly -> `dpb` stays 1 through the glitch; it falls 7 cycles after the final release; no extra `scen`.
- Simultaneous: raise `BtnL_raw` and `BtnC_raw` on the same cycle -> both `scen` outputs pulse in the same cycle; the other three channels stay 0.
- Reset mid-press: `reset_n`=0 for 1 cycle while a channel is in HOLD with the raw input still high -> all outputs 0 after the reset edge; one new `scen` 7 cycles after `reset_n` returns to 1.
- Short glitch: 1-cycle and 3-cycle pulses on every raw input -> all `scen` and `dpb` outputs remain 0.
